// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART frame constants and transmit-sequencer state encoding
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int FRAME_BITS_1STOP = 10;
  localparam int FRAME_BITS_2STOP = 11;
  localparam int DEFAULT_CLK_DIV  = 434;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ============================================================================
// uart_baud_gen : free-running bit-period divider, one-cycle tick per period
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int              c_CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(CLK_DIV - 1);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  logic [c_CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == c_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_ONE;
    end
  end

  assign o_tick = (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ============================================================================
// uart_tx_scheduler : round-robin byte arbiter and frame sequencer for UART TX
// Rev 1.0           : initial release
// ============================================================================
`default_nettype none

module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int STOP_BITS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_sched_en,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [8*NUM_REQ-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]     o_req_ack,
  output logic [2:0]             o_grant_id,
  output logic                   o_tx_enable,
  output logic                   o_tx_din_rdy,
  output logic [7:0]             o_tx_din_byte,
  output logic                   o_busy
);

  localparam int                 c_FRAME_BITS = (STOP_BITS == 2) ? FRAME_BITS_2STOP
                                                                 : FRAME_BITS_1STOP;
  localparam logic [3:0]         c_LAST_BIT   = 4'(c_FRAME_BITS - 1);
  localparam logic [2:0]         c_PTR_RST    = 3'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] c_ONE_HOT    = NUM_REQ'(1);

  tx_state_e   r_state;
  logic [3:0]  r_bit_cnt;
  logic        r_hold_valid;
  logic [7:0]  r_hold_byte;
  logic [2:0]  r_grant_id;
  logic [2:0]  r_ptr;

  logic        w_tick;
  logic [7:0]  w_bytes [8];
  logic [7:0]  w_valid;
  logic        w_hi_found, w_lo_found, w_any;
  logic [2:0]  w_hi_sel, w_lo_sel, w_sel;
  logic        w_grant, w_window, w_load;

  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .o_tick (w_tick)
  );

  // Pad requesters out to eight lanes so a 3-bit index always fits exactly.
  for (genvar g = 0; g < 8; g++) begin : g_slot
    if (g < NUM_REQ) begin : g_used
      assign w_bytes[g] = i_req_data[8*g +: 8];
      assign w_valid[g] = i_req_valid[g];
    end else begin : g_unused
      assign w_bytes[g] = 8'h00;
      assign w_valid[g] = 1'b0;
    end
  end

  // Lowest valid index above the pointer wins; otherwise wrap to the lowest at/below it.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_sel   = 3'd0;
    w_lo_found = 1'b0;
    w_lo_sel   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_valid[i]) begin
        if (i > int'(r_ptr)) begin
          w_hi_found = 1'b1;
          w_hi_sel   = 3'(i);
        end else begin
          w_lo_found = 1'b1;
          w_lo_sel   = 3'(i);
        end
      end
    end
    w_any = w_hi_found | w_lo_found;
    w_sel = w_hi_found ? w_hi_sel : w_lo_sel;
  end

  // Gated by rst so the combinational ack stays quiet while reset is held.
  assign w_grant  = !rst && !r_hold_valid && i_sched_en && w_any;
  assign w_window = (r_state == IDLE) || (r_state == SEND && r_bit_cnt == c_LAST_BIT);
  assign w_load   = o_tx_din_rdy && w_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_bit_cnt    <= 4'd0;
      r_hold_valid <= 1'b0;
      r_hold_byte  <= 8'h00;
      r_grant_id   <= 3'd0;
      r_ptr        <= c_PTR_RST;
    end else if (w_load) begin
      r_state      <= SEND;
      r_bit_cnt    <= 4'd0;
      r_hold_valid <= 1'b0;
    end else begin
      if (w_grant) begin
        r_hold_valid <= 1'b1;
        r_hold_byte  <= w_bytes[w_sel];
        r_grant_id   <= w_sel;
        r_ptr        <= w_sel;
      end
      if (w_tick && r_state == SEND) begin
        if (r_bit_cnt == c_LAST_BIT) begin
          r_state   <= IDLE;
          r_bit_cnt <= 4'd0;
        end else begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end
    end
  end

  assign o_req_ack     = w_grant ? (c_ONE_HOT << w_sel) : '0;
  assign o_grant_id    = r_grant_id;
  assign o_tx_enable   = w_tick;
  assign o_tx_din_rdy  = r_hold_valid && w_window;
  assign o_tx_din_byte = r_hold_byte;
  assign o_busy        = r_hold_valid || (r_state == SEND);

endmodule

`default_nettype wire
